alu_req_issuer: RTL and testbench
=================================

ALU_REQ_ISSUER -- requirements
Module: alu_req_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the operands.
REQ-002 SHALL have parameter ARITH_WIDTH, default 32, width of the arithmetic result and of rsp_data.
REQ-003 SHALL have parameter LOGIC_WIDTH, default 16, width of the logic result.
REQ-004 SHALL have parameter CMP_WIDTH, default 2, width of the compare result.
REQ-005 SHALL have parameter SHIFT_WIDTH, default 17, width of the shift result.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4 (power of two), request buffer entries.
REQ-007 SHALL have parameter TIMEOUT, default 7, maximum WAIT cycles.
REQ-008 SHALL use one clock and a synchronous, active-high reset: CLK  in  1  clock, all state on rising edge.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 req_valid  in  1  request offered; req_ready  out  1  request buffer not full.
REQ-011 req_func  in  4  ALU function code; req_a, req_b  in  DATA_WIDTH  signed operands.
REQ-012 alu_A, alu_B  out  DATA_WIDTH  operands driven to the ALU; alu_FUNC  out  4  function to the ALU.
REQ-013 Arith_OUT in ARITH_WIDTH, Logic_OUT in LOGIC_WIDTH, CMP_OUT in CMP_WIDTH, SHIFT_OUT in SHIFT_WIDTH  registered ALU results.
REQ-014 Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  ALU result-valid flags.
REQ-015 rsp_valid out 1, rsp_ready in 1  response handshake; rsp_data out ARITH_WIDTH result; rsp_unit out 2 unit code; rsp_err out 1 error.
REQ-016 busy  out  1  FSM not IDLE or buffer non-empty; level  out  clog2(FIFO_DEPTH)+1  buffer occupancy.

Function
REQ-017 SHALL accept a request when req_valid && req_ready; req_ready = (level < FIFO_DEPTH); a push while full is blocked even if a pop occurs the same cycle.
REQ-018 SHALL buffer {req_func, req_a, req_b} in FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; IDLE -> ISSUE when buffer non-empty.
REQ-020 ISSUE (1 cycle): drive alu_A/alu_B/alu_FUNC from head entry, pop the entry, clear timeout counter, -> WAIT.
REQ-021 alu_A/alu_B/alu_FUNC SHALL hold their last driven values in all states outside ISSUE.
REQ-022 Expected unit = func[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
REQ-023 WAIT: expected flag the only flag set -> capture result, rsp_err=0, -> RESP.
REQ-024 WAIT: any unexpected flag set -> rsp_data=0, rsp_err=1, -> RESP.
REQ-025 WAIT: no flag set -> increment counter; counter reaching TIMEOUT -> rsp_data=0, rsp_err=1, -> RESP.
REQ-026 Capture width rules: Arith_OUT as-is; Logic_OUT, CMP_OUT, SHIFT_OUT zero-extended to ARITH_WIDTH; rsp_unit = expected unit in all cases.
REQ-027 RESP: rsp_valid=1; rsp_data/rsp_unit/rsp_err stable while rsp_valid && !rsp_ready; on rsp_ready -> ISSUE if buffer non-empty else IDLE, rsp_valid=0 next cycle.
REQ-028 Latency from request acceptance into empty buffer and IDLE FSM to rsp_valid: 3 cycles (ISSUE, WAIT, RESP).
REQ-029 Only one operation in flight; requests keep buffering during WAIT/RESP.

Reset
REQ-030 RST high at a rising edge SHALL clear the buffer (level=0), FSM -> IDLE, rsp_valid=0, rsp_data=0, rsp_unit=0, rsp_err=0, alu_A=alu_B=0, alu_FUNC=0, counter=0, busy=0.
REQ-031 Reset mid-operation (any state) SHALL discard the in-flight operation and buffered requests with no response emitted.

Verification
REQ-032 Add: func=0000, A=0xFFFA, B=0xFFE7, ALU returns Arith_Flag=1 -> rsp_data=0xFFFFFFE1, rsp_unit=00, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-033 Shift: func=1111, B=0x000A, SHIFT_OUT=0x00014 -> rsp_data=0x00000014, rsp_unit=11; CMP func=1010, CMP_OUT=10 -> rsp_data=0x00000002, rsp_unit=10.
REQ-034 Burst 5 requests with rsp_ready=0 -> req_ready low after 4th buffered, responses return in order after rsp_ready=1, no loss or duplication.
REQ-035 ALU flags held 0 -> rsp_err=1, rsp_data=0 after 7 WAIT cycles; Logic_Flag returned for func=0001 -> rsp_err=1.
REQ-036 rsp_ready low 5 cycles -> rsp_data/unit/err unchanged throughout, single transfer on release.
REQ-037 RST pulse during WAIT with 2 entries buffered -> next cycle level=0, rsp_valid=0, alu_FUNC=0, no response thereafter.

Source files
------------

// File: rtl/alu_req_issuer.sv
// alu_req_issuer: buffers ALU requests in a small FIFO and issues them one at a
// time to an external ALU, waits for the matching result flag (or a timeout) and
// returns a single response per request over a valid/ready handshake.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_func, req_a, req_b payload
//   alu_A, alu_B, alu_FUNC        operands/function presented to the ALU
//   Arith/Logic/CMP/SHIFT_OUT     ALU results; *_Flag result-valid flags
//   rsp_valid/rsp_ready           response handshake; rsp_data, rsp_unit, rsp_err payload
//   busy                          FSM active or requests buffered
//   level                         request buffer occupancy
module alu_req_issuer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ARITH_WIDTH = 32,
    parameter int unsigned LOGIC_WIDTH = 16,
    parameter int unsigned CMP_WIDTH   = 2,
    parameter int unsigned SHIFT_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH  = 4,   // power of two, >= 2
    parameter int unsigned TIMEOUT     = 7
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_func,
    input  logic [DATA_WIDTH-1:0]         req_a,
    input  logic [DATA_WIDTH-1:0]         req_b,
    output logic [DATA_WIDTH-1:0]         alu_A,
    output logic [DATA_WIDTH-1:0]         alu_B,
    output logic [3:0]                    alu_FUNC,
    input  logic [ARITH_WIDTH-1:0]        Arith_OUT,
    input  logic [LOGIC_WIDTH-1:0]        Logic_OUT,
    input  logic [CMP_WIDTH-1:0]          CMP_OUT,
    input  logic [SHIFT_WIDTH-1:0]        SHIFT_OUT,
    input  logic                          Arith_Flag,
    input  logic                          Logic_Flag,
    input  logic                          CMP_Flag,
    input  logic                          SHIFT_Flag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ARITH_WIDTH-1:0]        rsp_data,
    output logic [1:0]                    rsp_unit,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 4 + 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  a_q, b_q;
    logic [3:0]             func_q;
    logic [ARITH_WIDTH-1:0] data_q, data_d;
    logic [1:0]             unit_q, unit_d;
    logic                   err_q, err_d;

    logic                   push, pop;
    logic [EW-1:0]          head;
    logic [3:0]             flags, exp_flag;
    logic [ARITH_WIDTH-1:0] capture;

    // A full buffer refuses a push even if the head is popped in the same cycle.
    assign req_ready = (level_q < LVL_FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == StIssue);
    assign head      = mem[rd_ptr_q];

    // The ALU sees the head entry during ISSUE and the last issued entry otherwise.
    assign alu_FUNC  = pop ? head[EW-1 -: 4] : func_q;
    assign alu_A     = pop ? head[2*DATA_WIDTH-1 -: DATA_WIDTH] : a_q;
    assign alu_B     = pop ? head[DATA_WIDTH-1:0] : b_q;

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = data_q;
    assign rsp_unit  = unit_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != StIdle) || (level_q != '0);
    assign level     = level_q;

    assign flags    = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    assign exp_flag = 4'b0001 << func_q[3:2];

    always_comb begin
        capture = '0;
        unique case (func_q[3:2])
            2'b00: capture = Arith_OUT;
            2'b01: capture = ARITH_WIDTH'(Logic_OUT);
            2'b10: capture = ARITH_WIDTH'(CMP_OUT);
            2'b11: capture = ARITH_WIDTH'(SHIFT_OUT);
            default: capture = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unit_d  = unit_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) state_d = StIssue;
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                unit_d = func_q[3:2];
                if (flags == exp_flag) begin
                    data_d  = capture;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (flags != 4'b0000) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th empty WAIT cycle.
                    cnt_d   = cnt_q + CNT_ONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = (level_q != '0) ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= {req_func, req_a, req_b};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            data_q   <= '0;
            unit_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            unit_q  <= unit_d;
            err_q   <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                func_q   <= head[EW-1 -: 4];
                a_q      <= head[2*DATA_WIDTH-1 -: DATA_WIDTH];
                b_q      <= head[DATA_WIDTH-1:0];
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_q <= level_q - LVL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_issuer.sv
// Self-checking bench for alu_req_issuer: directed scenarios followed by random
// traffic, compared against an in-order queue model of requests and responses.
module tb_alu_req_issuer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready;
    logic [3:0]  req_func;
    logic [15:0] req_a, req_b;
    logic [15:0] alu_A, alu_B;
    logic [3:0]  alu_FUNC;
    logic [31:0] Arith_OUT;
    logic [15:0] Logic_OUT;
    logic [1:0]  CMP_OUT;
    logic [16:0] SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_unit;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  level;

    always #5 CLK = ~CLK;

    alu_req_issuer dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_FUNC   (alu_FUNC),
        .Arith_OUT  (Arith_OUT),
        .Logic_OUT  (Logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .SHIFT_OUT  (SHIFT_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_Flag (SHIFT_Flag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_unit   (rsp_unit),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .level      (level)
    );

    // One request plus the ALU behaviour the bench will present while it is in flight.
    typedef struct {
        logic [3:0]  func;
        logic [15:0] a, b;
        logic [3:0]  flags;   // {shift, cmp, logic, arith}
        logic [31:0] arith;
        logic [15:0] lg;
        logic [1:0]  cmp;
        logic [16:0] sh;
        int          exp_lat;  // 0: latency not checked
        int          acc_cyc;
        bit          seen;
    } op_t;

    op_t pend[$];   // offered, not yet accepted
    op_t outq[$];   // accepted, response not yet transferred

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepted = 0;
    bit rand_mode = 1'b0;
    bit hold_rdy_low = 1'b0;
    int rdy_pct = 100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Exactly the expected unit's flag yields that unit's result, anything else is an error.
    function automatic logic exp_err(op_t o);
        return o.flags != (4'b0001 << o.func[3:2]);
    endfunction

    function automatic logic [31:0] exp_data(op_t o);
        if (exp_err(o)) return 32'h0;
        case (o.func[3:2])
            2'd0:    return o.arith;
            2'd1:    return {16'h0, o.lg};
            2'd2:    return {30'h0, o.cmp};
            default: return {15'h0, o.sh};
        endcase
    endfunction

    function automatic op_t mk(input logic [3:0] func, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] flags, input logic [31:0] arith,
                               input logic [15:0] lg, input logic [1:0] cmp,
                               input logic [16:0] sh, input int lat);
        op_t o;
        o.func = func; o.a = a; o.b = b; o.flags = flags;
        o.arith = arith; o.lg = lg; o.cmp = cmp; o.sh = sh;
        o.exp_lat = lat; o.acc_cyc = 0; o.seen = 1'b0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [3:0] oh;
        int r;
        o = mk(4'($urandom), 16'($urandom), 16'($urandom), 4'h0, $urandom, 16'($urandom),
               2'($urandom), 17'($urandom), 0);
        oh = 4'b0001 << o.func[3:2];
        r = $urandom_range(0, 9);
        if (r < 6) begin
            o.flags = oh;
        end else if (r < 8) begin
            o.flags = 4'($urandom);
            if (o.flags == oh || o.flags == 4'h0) o.flags = ~oh;
        end else if (r == 8) begin
            o.flags = 4'h0;
        end else begin
            o.flags = oh | (4'b0001 << (o.func[3:2] + 2'd1));
        end
        return o;
    endfunction

    // One clock: sample at the falling edge, check, then drive inputs for the next rising edge.
    task automatic step();
        @(negedge CLK);
        cyc++;
        if (rsp_valid) begin
            if (outq.size() == 0) begin
                check("spurious_rsp", rsp_valid, 1'b0);
            end else begin
                if (!outq[0].seen) begin
                    outq[0].seen = 1'b1;
                    if (outq[0].exp_lat > 0)
                        check("latency", 64'(cyc - outq[0].acc_cyc - 1), 64'(outq[0].exp_lat));
                end
                check("rsp_data", rsp_data, exp_data(outq[0]));
                check("rsp_unit", rsp_unit, outq[0].func[3:2]);
                check("rsp_err", rsp_err, exp_err(outq[0]));
            end
        end
        rsp_ready = hold_rdy_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        if (rsp_valid && rsp_ready && outq.size() > 0) void'(outq.pop_front());

        if (rand_mode && pend.size() == 0 && $urandom_range(0, 99) < 40) pend.push_back(rand_op());
        if (pend.size() > 0) begin
            req_valid = 1'b1;
            req_func  = pend[0].func;
            req_a     = pend[0].a;
            req_b     = pend[0].b;
        end else begin
            req_valid = 1'b0;
            req_func  = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
        end
        if (req_valid && req_ready) begin
            op_t o;
            o = pend.pop_front();
            o.acc_cyc = cyc;
            outq.push_back(o);
            accepted++;
        end

        if (outq.size() > 0) begin
            Arith_OUT = outq[0].arith;
            Logic_OUT = outq[0].lg;
            CMP_OUT   = outq[0].cmp;
            SHIFT_OUT = outq[0].sh;
            {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = outq[0].flags;
        end else begin
            {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = 4'h0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || outq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 64'(pend.size() + outq.size()), 64'd0);
    endtask

    initial begin
        logic [15:0] a0, b0;
        int acc0;
        RST = 1'b1;
        req_valid = 1'b0; req_func = 4'h0; req_a = 16'h0; req_b = 16'h0;
        rsp_ready = 1'b0;
        Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
        {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = 4'h0;
        repeat (3) @(negedge CLK);
        check("rst_level", level, 3'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_unit", rsp_unit, 2'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_alu_A", alu_A, 16'h0);
        check("rst_alu_B", alu_B, 16'h0);
        check("rst_alu_FUNC", alu_FUNC, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        RST = 1'b0;

        // Signed add: -6 + -25 computed at the result width.
        a0 = 16'hFFFA; b0 = 16'hFFE7;
        pend.push_back(mk(4'b0000, a0, b0, 4'b0001,
                          {{16{a0[15]}}, a0} + {{16{b0[15]}}, b0}, 16'h1234, 2'd1, 17'h1, 3));
        drain(30);
        step();
        check("idle_busy", busy, 1'b0);
        check("idle_level", level, 3'd0);
        check("hold_alu_A", alu_A, a0);
        check("hold_alu_B", alu_B, b0);
        check("hold_alu_FUNC", alu_FUNC, 4'b0000);

        pend.push_back(mk(4'b1111, 16'h0001, 16'h000A, 4'b1000, 32'hDEAD, 16'hBEEF, 2'd3,
                          17'h00014, 3));
        drain(30);
        pend.push_back(mk(4'b1010, 16'h0005, 16'h0003, 4'b0100, 32'hDEAD, 16'hBEEF, 2'b10,
                          17'h1FFFF, 3));
        drain(30);
        pend.push_back(mk(4'b0110, 16'h00F0, 16'h0F0F, 4'b0010, 32'hDEAD, 16'hFFFF, 2'd0,
                          17'h0, 3));
        drain(30);

        // Timeout, then a wrong-unit flag.
        pend.push_back(mk(4'b0000, 16'h0001, 16'h0002, 4'b0000, 32'h3, 16'h0, 2'd0, 17'h0, 9));
        drain(40);
        pend.push_back(mk(4'b0001, 16'h0001, 16'h0002, 4'b0010, 32'h3, 16'h5, 2'd0, 17'h0, 3));
        drain(30);

        // Response held off for several cycles, then a single transfer.
        hold_rdy_low = 1'b1;
        pend.push_back(mk(4'b1001, 16'h0003, 16'h0004, 4'b0100, 32'h0, 16'h0, 2'b11, 17'h0, 3));
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        check("stall_rsp_seen", rsp_valid, 1'b1);
        repeat (5) step();
        hold_rdy_low = 1'b0;
        drain(10);
        repeat (3) step();

        // Burst into a stalled response path.
        hold_rdy_low = 1'b1;
        acc0 = accepted;
        for (int i = 0; i < 6; i++) begin
            op_t o;
            o = rand_op();
            o.flags = 4'b0001 << o.func[3:2];
            pend.push_back(o);
        end
        repeat (12) step();
        check("burst_req_ready", req_ready, 1'b0);
        check("burst_level", level, 3'd4);
        check("burst_accepted", 64'(accepted - acc0), 64'd5);
        check("burst_busy", busy, 1'b1);
        hold_rdy_low = 1'b0;
        drain(100);
        repeat (3) step();

        // Reset while WAIT is timing out and two entries are buffered.
        pend.push_back(mk(4'b0101, 16'h0011, 16'h0022, 4'b0000, 32'h0, 16'h0, 2'd0, 17'h0, 0));
        pend.push_back(rand_op());
        pend.push_back(rand_op());
        repeat (5) step();
        check("pre_rst_level", level, 3'd2);
        check("pre_rst_alu_FUNC", alu_FUNC, 4'b0101);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_level", level, 3'd0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_alu_FUNC", alu_FUNC, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        pend.delete();
        outq.delete();
        RST = 1'b0;
        repeat (20) step();

        // Random traffic with random back-pressure.
        rand_mode = 1'b1;
        rdy_pct = 60;
        repeat (3000) step();
        rand_mode = 1'b0;
        rdy_pct = 100;
        drain(200);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
